// File: rtl/pc_redirect.sv
// pc_redirect: in-order predicted-next-PC queue checked against execute's resolved PC; redirects IFU and flushes on mismatch.
// Define YSYX_23060251_BPU_STAT_EN to add resolve/mispredict counters.
module pc_redirect #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pred_valid_i,
  output logic            pred_ready_o,
  input  logic [PC_W-1:0] pred_pc_i,
  input  logic            res_valid_i,
  output logic            res_ready_o,
  input  logic [PC_W-1:0] res_npc_i,
  output logic            redirect_valid_o,
  input  logic            redirect_ready_i,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic            flush_o
`ifdef YSYX_23060251_BPU_STAT_EN
  ,
  output logic [31:0]     stat_resolved_o,
  output logic [31:0]     stat_mispred_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] NORMAL = 1'b0;
  localparam logic [0:0] REDIR  = 1'b1;
  logic [0:0]      state_q, state_d;
  logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PC_W-1:0] mem_q [DEPTH];
  logic [PC_W-1:0] mem_d [DEPTH];
  logic [PC_W-1:0] rpc_q, rpc_d;
  logic            full, empty, enq, deq, mis, redir_fire;
  always_comb begin
    full             = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    empty            = wptr_q == rptr_q;
    pred_ready_o     = (state_q == NORMAL) && !full;
    res_ready_o      = (state_q == NORMAL) && !empty;
    redirect_valid_o = state_q == REDIR;
    redirect_pc_o    = rpc_q;
    enq              = pred_valid_i && pred_ready_o;
    deq              = res_valid_i && res_ready_o;
    mis              = deq && (mem_q[rptr_q[AW-1:0]] != res_npc_i);
    redir_fire       = redirect_valid_o && redirect_ready_i;
    flush_o          = redir_fire;
    state_d          = redir_fire ? NORMAL : mis ? REDIR : state_q;
    // the redirect exit empties the queue, discarding anything enqueued meanwhile
    wptr_d           = redir_fire ? '0 : wptr_q + {{AW{1'b0}}, enq};
    rptr_d           = redir_fire ? '0 : rptr_q + {{AW{1'b0}}, deq};
    rpc_d            = mis ? res_npc_i : rpc_q;
    for (int i = 0; i < DEPTH; i++)
      mem_d[i] = (enq && wptr_q[AW-1:0] == AW'(i)) ? pred_pc_i : mem_q[i];
  end
`ifdef YSYX_23060251_BPU_STAT_EN
  logic [31:0] res_cnt_q, res_cnt_d, mis_cnt_q, mis_cnt_d;
  always_comb begin
    res_cnt_d       = res_cnt_q + {31'b0, deq};
    mis_cnt_d       = mis_cnt_q + {31'b0, mis};
    stat_resolved_o = res_cnt_q;
    stat_mispred_o  = mis_cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      res_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      res_cnt_q <= res_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end
`endif
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (reset) begin
      state_q <= NORMAL;
      wptr_q  <= '0;
      rptr_q  <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rpc_q   <= rpc_d;
    end
  end
endmodule

// File: tb/tb_pc_redirect.sv
// tb_pc_redirect: queue-level reference model with a redirect scoreboard checked by an independent monitor.
module tb_pc_redirect;
  localparam int DEPTH = 4;
  localparam int PC_W = 32;
  logic clk = 0, reset = 1;
  logic pred_valid_i = 0, res_valid_i = 0, redirect_ready_i = 0;
  logic [PC_W-1:0] pred_pc_i = '0, res_npc_i = '0;
  logic pred_ready_o, res_ready_o, redirect_valid_o, flush_o;
  logic [PC_W-1:0] redirect_pc_o;
`ifdef YSYX_23060251_BPU_STAT_EN
  logic [31:0] stat_resolved_o, stat_mispred_o;
  int unsigned m_res, m_mis;
`endif
  int checks = 0, errors = 0;
  logic [PC_W-1:0] mq[$];
  logic [PC_W-1:0] sb[$];
  bit mredir = 0;
  logic [PC_W-1:0] mpc = '0;
  int nredir = 0;

  pc_redirect #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clock(clk), .reset(reset),
    .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o), .pred_pc_i(pred_pc_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_npc_i(res_npc_i),
    .redirect_valid_o(redirect_valid_o), .redirect_ready_i(redirect_ready_i),
    .redirect_pc_o(redirect_pc_o), .flush_o(flush_o)
`ifdef YSYX_23060251_BPU_STAT_EN
    , .stat_resolved_o(stat_resolved_o), .stat_mispred_o(stat_mispred_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every redirect handshake must match the oldest expected redirect
  always @(negedge clk) if (!reset) begin
    chk("flush_o", flush_o, redirect_valid_o & redirect_ready_i);
    if (redirect_valid_o && redirect_ready_i) begin
      nredir++;
      if (sb.size() == 0) chk("unexpected_redirect", redirect_pc_o, 64'hx);
      else chk("redirect_pc", redirect_pc_o, sb.pop_front());
    end
  end

  task automatic model_reset();
    mq.delete(); sb.delete(); mredir = 0; mpc = '0;
`ifdef YSYX_23060251_BPU_STAT_EN
    m_res = 0; m_mis = 0;
`endif
  endtask

  task automatic do_reset();
    reset = 1; pred_valid_i = 0; res_valid_i = 0; redirect_ready_i = 0;
    @(posedge clk); #1;
    reset = 0; model_reset();
    @(negedge clk);
    chk("rst_pred_ready", pred_ready_o, 1);
    chk("rst_res_ready", res_ready_o, 0);
    chk("rst_redirect_valid", redirect_valid_o, 0);
    chk("rst_redirect_pc", redirect_pc_o, 0);
    chk("rst_flush", flush_o, 0);
`ifdef YSYX_23060251_BPU_STAT_EN
    chk("rst_stat_resolved", stat_resolved_o, 0);
    chk("rst_stat_mispred", stat_mispred_o, 0);
`endif
    @(posedge clk); #1;
  endtask

  // one cycle: apply inputs, check readies against the model, then advance the model
  task automatic step(input bit pv, input logic [PC_W-1:0] ppc, input bit rv,
                      input logic [PC_W-1:0] rnpc, input bit rr);
    bit epr, err, pf, rf;
    logic [PC_W-1:0] h;
    pred_valid_i = pv; pred_pc_i = ppc; res_valid_i = rv; res_npc_i = rnpc; redirect_ready_i = rr;
    epr = !mredir && mq.size() < DEPTH;
    err = !mredir && mq.size() > 0;
    @(negedge clk);
    chk("pred_ready", pred_ready_o, epr);
    chk("res_ready", res_ready_o, err);
    chk("redirect_valid", redirect_valid_o, mredir);
    if (mredir) chk("redirect_pc_hold", redirect_pc_o, mpc);
`ifdef YSYX_23060251_BPU_STAT_EN
    chk("stat_resolved", stat_resolved_o, m_res);
    chk("stat_mispred", stat_mispred_o, m_mis);
`endif
    if (mredir) begin
      if (rr) begin mq.delete(); mredir = 0; end
    end else begin
      pf = pv && epr;
      rf = rv && err;
      if (rf) begin
        h = mq.pop_front();
`ifdef YSYX_23060251_BPU_STAT_EN
        m_res++;
`endif
        if (h != rnpc) begin
          mredir = 1; mpc = rnpc; sb.push_back(rnpc);
`ifdef YSYX_23060251_BPU_STAT_EN
          m_mis++;
`endif
        end
      end
      if (pf) mq.push_back(ppc);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(); step(0, '0, 0, '0, 0); endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [PC_W-1:0] p;
    int r0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    // four matching predictions, queue fills
    for (int i = 1; i <= 4; i++) step(1, 32'h80000000 + 32'(4 * i), 0, '0, 0);
    chk("full_pred_ready", pred_ready_o, 0);
    for (int i = 1; i <= 4; i++) step(0, '0, 1, 32'h80000000 + 32'(4 * i), 0);
    chk("no_redirects", nredir, 0);
    // mispredict with IFU stalling for three cycles
    step(1, 32'h80000010, 0, '0, 0);
    step(0, '0, 1, 32'h80000100, 0);
    repeat (3) step(0, '0, 1, '0, 0);
    step(0, '0, 0, '0, 1);
    idle();
    chk("one_redirect", nredir, 1);
    // resolve against an empty queue stalls
    repeat (5) step(0, '0, 1, 32'h1234, 0);
    step(1, 32'h80000004, 0, '0, 0);
    chk("res_ready_after_enq", res_ready_o, 1);
    step(0, '0, 1, 32'h80000004, 0);
    // full plus simultaneous enqueue/resolve across three wrap passes
    for (int pass = 0; pass < 3; pass++) begin
      for (int i = 0; i < DEPTH; i++) step(1, 32'(pass * 16 + i), 0, '0, 0);
      step(1, 32'hAAAA0000 + 32'(pass), 1, 32'(pass * 16), 0);
      step(1, 32'hAAAA0000 + 32'(pass), 0, '0, 0);
      for (int i = 1; i < DEPTH; i++) step(0, '0, 1, 32'(pass * 16 + i), 0);
      step(0, '0, 1, 32'hAAAA0000 + 32'(pass), 0);
    end
    // reset while redirecting
    step(1, 32'h80000020, 0, '0, 0);
    step(0, '0, 1, 32'hDEAD0000, 0);
    idle();
    do_reset();
    chk("post_reset_redirect_pc", redirect_pc_o, 0);
`ifdef YSYX_23060251_BPU_STAT_EN
    for (int i = 0; i < 10; i++) begin
      step(1, 32'(i), 0, '0, 0);
      step(0, '0, 1, (i % 3 == 0 && i > 0) ? 32'hF00 : 32'(i), 0);
      if (mredir) step(0, '0, 0, '0, 1);
    end
    idle();
    chk("stat_resolved_10", stat_resolved_o, 10);
    chk("stat_mispred_3", stat_mispred_o, 3);
    @(negedge clk);
    force dut.mis_cnt_q = 32'hFFFFFFFF;
    @(posedge clk); #1;
    release dut.mis_cnt_q;
    m_mis = 32'hFFFFFFFF;
    step(1, 32'h10, 0, '0, 0);
    step(0, '0, 1, 32'h20, 0);
    step(0, '0, 0, '0, 1);
    chk("stat_mispred_wrap", stat_mispred_o, 0);
`endif
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r0 = int'($urandom_range(0, 3));
      p = (mq.size() > 0 && r0 != 0) ? mq[0] : $urandom();
      step($urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 2) != 0, p,
           $urandom_range(0, 2) == 0);
    end
    for (int n = 0; n < 10 && mredir; n++) step(0, '0, 0, '0, 1);
    repeat (2) idle();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_redirect.md
# pc_redirect

Branch-resolution and redirect unit. Paired with the front-end pre-decoder that emits a predicted next PC per instruction: it queues those predictions in program order, compares each against the actual next PC computed by execute, and on mismatch issues a redirect PC to the fetch unit plus a pipeline flush. Sits between decode (enqueue side), execute (resolve side) and IFU (redirect side).

## Interface

**Parameters**
- `DEPTH`, default 4: prediction queue entries; power of two, ≥2.
- `PC_W`, default 32: PC width.

**Ports**
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `pred_valid_i` in 1: decode presents a prediction.
- `pred_ready_o` out 1: queue accepts the prediction.
- `pred_pc_i` in PC_W: predicted next PC (pc+imm for branch/jal, pc+4 otherwise).
- `res_valid_i` in 1: execute presents the resolved next PC of the oldest instruction.
- `res_ready_o` out 1: resolution accepted.
- `res_npc_i` in PC_W: actual next PC (taken target, rs1+imm, csr target, or pc+4).
- `redirect_valid_o` out 1: redirect request to IFU.
- `redirect_ready_i` in 1: IFU accepts the redirect.
- `redirect_pc_o` out PC_W: PC to refetch from.
- `flush_o` out 1: kill younger in-flight instructions.
- `stat_resolved_o` out 32, `stat_mispred_o` out 32: present only with the macro below.

## Operation

- Queue: circular FIFO, `DEPTH` entries, write/read pointers of log2(DEPTH)+1 bits; full = MSBs differ and low bits equal; empty = pointers equal. Pointers wrap naturally.
- FSM, two states:
  - NORMAL: `pred_ready_o` = !full; `res_ready_o` = !empty; `redirect_valid_o` = 0.
  - REDIR: `pred_ready_o` = 0; `res_ready_o` = 0; `redirect_valid_o` = 1.
- Enqueue: `pred_valid_i & pred_ready_o` writes `pred_pc_i` at wptr, wptr+1.
- Resolve: `res_valid_i & res_ready_o` pops head, rptr+1, compares head with `res_npc_i` (full PC_W equality).
  - Match: stay NORMAL.
  - Mismatch: latch `res_npc_i` into `redirect_pc_o`, go REDIR.
- REDIR exit: on `redirect_valid_o & redirect_ready_i`, both pointers reset to 0 (queue empty), go NORMAL.
- `flush_o` = `redirect_valid_o & redirect_ready_i` (combinational, one cycle per redirect).
- Resolve while empty: `res_ready_o` = 0, execute stalls; no compare.
- Simultaneous enqueue and resolve in NORMAL: both occur, count unchanged. Full plus resolve: enqueue is still refused that cycle (no bypass through pop).
- An enqueue in the same cycle as a mismatching resolve is performed, then discarded by the REDIR clear.
- `redirect_pc_o` holds its value until the next mismatch; it is only meaningful while `redirect_valid_o` = 1.
- Reset (any state, including mid-REDIR): state NORMAL, pointers 0, `redirect_pc_o` = 0, counters 0.

## Timing

- Reset values: `pred_ready_o` = 1, `res_ready_o` = 0, `redirect_valid_o` = 0, `redirect_pc_o` = 0, `flush_o` = 0, stats 0.
- Enqueue to resolvable: 1 cycle (`res_ready_o` rises the cycle after the first write).
- Mismatching resolve at edge N: `redirect_valid_o` = 1 in cycle N+1.
- `redirect_valid_o` stays asserted, with `redirect_pc_o` stable, until `redirect_ready_i`. No retraction.
- Redirect handshake in cycle M: `flush_o` = 1 in M; NORMAL with an empty queue from M+1; `pred_ready_o` = 1 in M+1.
- Minimum mispredict penalty in this block: 1 cycle (ready held high by IFU).

## Configuration

- `YSYX_23060251_BPU_STAT_EN`
  - Defined: ports `stat_resolved_o` and `stat_mispred_o` exist.
    - `stat_resolved_o` increments on every resolve handshake.
    - `stat_mispred_o` increments on every mismatching resolve.
    - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by `reset`.
  - Undefined: ports and counters are absent. All other behaviour is identical.

## Test plan

- Reset, then 4 enqueues of 0x80000004/08/0C/10 with resolves of the same values: 0 redirects, `flush_o` never high. After the 4th enqueue, `pred_ready_o` = 0 (DEPTH = 4).
- Enqueue 0x80000010, resolve with 0x80000100: `redirect_valid_o` = 1 next cycle with `redirect_pc_o` = 0x80000100. Hold `redirect_ready_i` = 0 for 3 cycles: valid and PC are stable and `res_ready_o` = 0. Raise ready: `flush_o` pulses 1 cycle, and the queue is empty the next cycle.
- `res_valid_i` = 1 with an empty queue for 5 cycles: `res_ready_o` = 0 throughout and no state change. Then enqueue 0x80000004: `res_ready_o` = 1 one cycle later.
- Full queue, then same-cycle `pred_valid_i` and resolve: pop occurs, enqueue refused. Next cycle the same prediction is accepted, and pointer wrap is checked across 3 full passes.
- Assert `reset` while in REDIR: next cycle `redirect_valid_o` = 0, `pred_ready_o` = 1, `redirect_pc_o` = 0, and the queue is empty.
- With `YSYX_23060251_BPU_STAT_EN`: 10 resolves, 3 mismatching → `stat_resolved_o` = 10, `stat_mispred_o` = 3. Preload `stat_mispred_o` at 0xFFFFFFFF via force, then one mismatch → 0.
